hn_router_eject_dec: RTL and testbench

//  Ejection-side counterpart of the home-node SAM stamping stage. Sits between a router

---
 rtl/hn_router_eject_dec_if.sv | 34 +++
 rtl/hn_router_eject_dec.sv | 227 ++++++++++++++++++++++
 tb/tb_hn_router_eject_dec.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hn_router_eject_dec_if.sv
// Router-local-port and device-side signal bundle for the home-node ejection decoder.
// master = router/device environment, slave = the ejection decoder.
interface hn_router_eject_dec_if #(
  parameter int unsigned VC_NUM = 2,
  parameter int unsigned FLIT_W = 256,
  parameter int unsigned CID_W  = 8
);
  localparam int unsigned VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  logic              flit_v_i;
  logic [FLIT_W-1:0] flit_i;
  logic [VC_W-1:0]   flit_vc_id_i;
  logic              lcrd_v_o;
  logic [VC_W-1:0]   lcrd_id_o;
  logic              dev_v_o;
  logic              dev_ready_i;
  logic [FLIT_W-1:0] dev_flit_o;
  logic [CID_W-1:0]  dev_src_cid_o;
  logic              tgt_err_o;
  logic              ovf_err_o;
  logic [15:0]       drop_cnt_o;

  modport master (
    output flit_v_i, flit_i, flit_vc_id_i, dev_ready_i,
    input  lcrd_v_o, lcrd_id_o, dev_v_o, dev_flit_o, dev_src_cid_o,
           tgt_err_o, ovf_err_o, drop_cnt_o
  );

  modport slave (
    input  flit_v_i, flit_i, flit_vc_id_i, dev_ready_i,
    output lcrd_v_o, lcrd_id_o, dev_v_o, dev_flit_o, dev_src_cid_o,
           tgt_err_o, ovf_err_o, drop_cnt_o
  );
endinterface

// File: rtl/hn_router_eject_dec.sv
// Home-node ejection stage: per-VC credit FIFOs, target check, round-robin delivery
// to the device with source (x,y) decoded back into a core id.
package hn_router_eject_dec_pkg;
  localparam int unsigned NODE_NUM_X_DIMESION = 4;
  localparam int unsigned NODE_ID_X_W         = 2;
  localparam int unsigned NODE_ID_Y_W         = 2;
  localparam int unsigned DEV_PORT_W          = 2;
  localparam int unsigned DEV_ID_W            = 2;
  localparam int unsigned FLIT_W              = 256;

  typedef struct packed {
    logic [DEV_ID_W-1:0]    device_id;
    logic [DEV_PORT_W-1:0]  device_port;
    logic [NODE_ID_Y_W-1:0] y_position;
    logic [NODE_ID_X_W-1:0] x_position;
  } node_id_t;

  localparam int unsigned NODE_ID_W = $bits(node_id_t);
  localparam int unsigned DATA_W    = FLIT_W - 2 * NODE_ID_W;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    node_id_t          src_id;
    node_id_t          tgt_id;
  } flit_payload_t;
endpackage

module hn_router_eject_dec
  import hn_router_eject_dec_pkg::*;
#(
  parameter int unsigned VC_NUM   = 2,
  parameter int unsigned VC_DEPTH = 4,
  parameter int unsigned CID_W    = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NODE_ID_X_W-1:0] node_id_x_i,
  input  logic [NODE_ID_Y_W-1:0] node_id_y_i,
  hn_router_eject_dec_if.slave   bus
);

  localparam int unsigned VC_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int unsigned PTR_W  = (VC_DEPTH > 1) ? $clog2(VC_DEPTH) : 1;
  localparam int unsigned CID_XW = CID_W + 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(VC_DEPTH - 1);

  typedef struct packed {
    logic          drop;
    flit_payload_t flit;
  } entry_t;

  typedef enum logic {ST_ARB, ST_HOLD} state_e;

  entry_t             mem    [VC_NUM][VC_DEPTH];
  logic [PTR_W:0]     wr_ptr [VC_NUM];
  logic [PTR_W:0]     rd_ptr [VC_NUM];
  entry_t             head   [VC_NUM];
  logic [VC_NUM-1:0]  empty;
  logic [VC_NUM-1:0]  full;

  flit_payload_t      in_flit;
  logic [VC_W-1:0]    wr_vc;
  logic               tgt_mismatch;
  logic               wr_en;
  logic               ovf;

  logic [VC_W-1:0]    rr_prio_q;
  logic [VC_W-1:0]    rr_vc;
  logic [VC_W-1:0]    cand;
  logic               rr_found;

  state_e             state_q, state_d;
  logic [VC_W-1:0]    hold_vc_q, hold_vc_d;

  logic [VC_W-1:0]    sel_vc;
  logic               sel_valid;
  entry_t             head_sel;
  logic               dev_v;
  logic               silent_drop;
  logic               pop_en;
  logic [CID_XW-1:0]  cid_wide;

  logic               lcrd_v_q;
  logic [VC_W-1:0]    lcrd_id_q;
  logic               tgt_err_q;
  logic               ovf_err_q;
  logic [15:0]        drop_cnt_q;
  logic [16:0]        drop_sum;

  // Pointers carry one extra wrap bit so equal indices resolve to full vs empty
  function automatic logic [PTR_W:0] ptr_inc(input logic [PTR_W:0] p);
    if (p[PTR_W-1:0] == LAST_IDX) return {~p[PTR_W], PTR_W'(0)};
    return p + (PTR_W+1)'(1);
  endfunction

  always_comb begin
    empty = '0;
    full  = '0;
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      empty[v] = (wr_ptr[v] == rd_ptr[v]);
      full[v]  = (wr_ptr[v][PTR_W-1:0] == rd_ptr[v][PTR_W-1:0]) &&
                 (wr_ptr[v][PTR_W] != rd_ptr[v][PTR_W]);
      head[v]  = mem[v][rd_ptr[v][PTR_W-1:0]];
    end
  end

  // A full VC still accepts when its head leaves on the same edge
  always_comb begin
    in_flit      = bus.flit_i;
    wr_vc        = bus.flit_vc_id_i;
    tgt_mismatch = (in_flit.tgt_id.x_position  != node_id_x_i) ||
                   (in_flit.tgt_id.y_position  != node_id_y_i) ||
                   (in_flit.tgt_id.device_port != '0) ||
                   (in_flit.tgt_id.device_id   != '0);
    wr_en        = bus.flit_v_i && (!full[wr_vc] || (pop_en && (sel_vc == wr_vc)));
    ovf          = bus.flit_v_i && !wr_en;
  end

  // First non-empty VC at or after the priority pointer
  always_comb begin
    rr_found = 1'b0;
    rr_vc    = '0;
    cand     = '0;
    for (int unsigned i = 0; i < VC_NUM; i++) begin
      cand = VC_W'((32'(rr_prio_q) + i) % VC_NUM);
      if (!rr_found && !empty[cand]) begin
        rr_found = 1'b1;
        rr_vc    = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_ARB;
      hold_vc_q <= '0;
    end else begin
      state_q   <= state_d;
      hold_vc_q <= hold_vc_d;
    end
  end

  // A presented valid flit keeps its grant until the device takes it
  always_comb begin
    state_d   = state_q;
    hold_vc_d = hold_vc_q;
    case (state_q)
      ST_ARB: begin
        if (dev_v && !bus.dev_ready_i) begin
          state_d   = ST_HOLD;
          hold_vc_d = sel_vc;
        end
      end
      ST_HOLD: begin
        if (bus.dev_ready_i) state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_comb begin
    sel_vc    = rr_vc;
    sel_valid = rr_found;
    if (state_q == ST_HOLD) begin
      sel_vc    = hold_vc_q;
      sel_valid = 1'b1;
    end
    head_sel    = head[sel_vc];
    dev_v       = sel_valid && !head_sel.drop;
    silent_drop = sel_valid && head_sel.drop;
    pop_en      = (dev_v && bus.dev_ready_i) || silent_drop;
    if ((head_sel.flit.src_id.x_position == '0) && (head_sel.flit.src_id.y_position == '0))
      cid_wide = '0;
    else
      cid_wide = CID_XW'(head_sel.flit.src_id.y_position) * CID_XW'(NODE_NUM_X_DIMESION) +
                 CID_XW'(head_sel.flit.src_id.x_position) - CID_XW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_vc][wr_ptr[wr_vc][PTR_W-1:0]] <= {tgt_mismatch, in_flit};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
      end
      rr_prio_q <= '0;
    end else begin
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        if (wr_en && (wr_vc == VC_W'(v)))   wr_ptr[v] <= ptr_inc(wr_ptr[v]);
        if (pop_en && (sel_vc == VC_W'(v))) rd_ptr[v] <= ptr_inc(rd_ptr[v]);
      end
      if (pop_en) rr_prio_q <= VC_W'((32'(sel_vc) + 32'd1) % VC_NUM);
    end
  end

  assign drop_sum = 17'(drop_cnt_q) + 17'(ovf) + 17'(silent_drop);

  // Credit per pop, sticky errors, saturating drop counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lcrd_v_q   <= 1'b0;
      lcrd_id_q  <= '0;
      tgt_err_q  <= 1'b0;
      ovf_err_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      lcrd_v_q <= pop_en;
      if (pop_en) lcrd_id_q <= sel_vc;
      if (bus.flit_v_i && tgt_mismatch) tgt_err_q <= 1'b1;
      if (ovf) ovf_err_q <= 1'b1;
      drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  assign bus.lcrd_v_o      = lcrd_v_q;
  assign bus.lcrd_id_o     = lcrd_id_q;
  assign bus.dev_v_o       = dev_v;
  assign bus.dev_flit_o    = head_sel.flit;
  assign bus.dev_src_cid_o = cid_wide[CID_W-1:0];
  assign bus.tgt_err_o     = tgt_err_q;
  assign bus.ovf_err_o     = ovf_err_q;
  assign bus.drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_hn_router_eject_dec.sv
// Scoreboard bench for hn_router_eject_dec: per-VC expected queues filled at send time,
// a negedge monitor checks deliveries, stalls and credits against them.
module tb_hn_router_eject_dec;
  localparam int unsigned VC_NUM   = 2;
  localparam int unsigned VC_DEPTH = 4;
  localparam int unsigned CID_W    = 8;
  localparam int unsigned FLIT_W   = 256;
  localparam int unsigned NX       = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] node_x;
  logic [1:0] node_y;

  hn_router_eject_dec_if #(.VC_NUM(VC_NUM), .FLIT_W(FLIT_W), .CID_W(CID_W)) bus ();

  hn_router_eject_dec #(.VC_NUM(VC_NUM), .VC_DEPTH(VC_DEPTH), .CID_W(CID_W)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .node_id_x_i (node_x),
    .node_id_y_i (node_y),
    .bus         (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [FLIT_W-1:0] flit;
    logic [CID_W-1:0]  cid;
  } exp_t;

  exp_t exp_q [VC_NUM][$];
  int   deliv_log[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cr[VC_NUM];
  int   got_cr[VC_NUM];
  int   outstanding[VC_NUM];
  int   exp_drop;
  bit   exp_tgt_err;
  bit   exp_ovf_err;
  int   seq = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Core id of a source (x,y): origin is core 0, otherwise row-major index minus one
  function automatic logic [7:0] cid_of(input int x, input int y);
    if (x == 0 && y == 0) return 8'd0;
    return 8'((y * NX + x - 1) & 255);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one flit for the coming edge and records what the device must see
  task automatic drive_flit(input int vc, input logic [7:0] tgt, input int sx, input int sy);
    logic [255:0] f;
    exp_t e;
    f = '0;
    for (int i = 2; i < 8; i++) f[i*32 +: 32] = $urandom;
    f[7:0]   = tgt;
    f[9:8]   = 2'(sx);
    f[11:10] = 2'(sy);
    f[15:12] = 4'($urandom);
    f[23:16] = 8'(vc);
    f[55:24] = 32'(seq);
    seq++;
    bus.flit_v_i     = 1'b1;
    bus.flit_i       = f;
    bus.flit_vc_id_i = 1'(vc);
    if (!(tgt[1:0] == node_x && tgt[3:2] == node_y && tgt[7:4] == 4'd0)) exp_tgt_err = 1'b1;
    if (outstanding[vc] >= VC_DEPTH) begin
      exp_drop++;
      exp_ovf_err = 1'b1;
    end else begin
      outstanding[vc]++;
      exp_cr[vc]++;
      if (tgt[1:0] == node_x && tgt[3:2] == node_y && tgt[7:4] == 4'd0) begin
        e.flit = f;
        e.cid  = cid_of(sx, sy);
        exp_q[vc].push_back(e);
      end else begin
        exp_drop++;
      end
    end
  endtask

  task automatic send(input int vc, input logic [7:0] tgt, input int sx, input int sy);
    drive_flit(vc, tgt, sx, sy);
    tick();
    bus.flit_v_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  function automatic int sat_drop();
    return (exp_drop > 65535) ? 65535 : exp_drop;
  endfunction

  // Monitor: deliveries, stall stability and credit returns
  logic         wait_prev = 1'b0;
  logic [255:0] prev_flit;
  logic [7:0]   prev_cid;
  always @(negedge clk) begin
    int   vc;
    int   cid_vc;
    exp_t e;
    if (!rstn) begin
      wait_prev = 1'b0;
    end else begin
      if (wait_prev) begin
        check("stall_valid", 256'(bus.dev_v_o), 256'(1));
        check("stall_flit", bus.dev_flit_o, prev_flit);
        check("stall_cid", 256'(bus.dev_src_cid_o), 256'(prev_cid));
      end
      if (bus.dev_v_o && bus.dev_ready_i) begin
        vc = int'(bus.dev_flit_o[23:16]);
        if (vc >= VC_NUM || exp_q[vc].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_delivery: got flit %0h expected none", bus.dev_flit_o);
        end else begin
          e = exp_q[vc].pop_front();
          check("deliver_flit", bus.dev_flit_o, e.flit);
          check("deliver_cid", 256'(bus.dev_src_cid_o), 256'(e.cid));
          deliv_log.push_back(vc);
        end
      end
      if (bus.lcrd_v_o) begin
        cid_vc = int'(bus.lcrd_id_o);
        got_cr[cid_vc]++;
        outstanding[cid_vc]--;
        checks++;
        if (got_cr[cid_vc] > exp_cr[cid_vc]) begin
          errors++;
          $display("FAIL credit_vc%0d: got %0d credits expected at most %0d",
                   cid_vc, got_cr[cid_vc], exp_cr[cid_vc]);
        end
      end
      wait_prev = bus.dev_v_o && !bus.dev_ready_i;
      prev_flit = bus.dev_flit_o;
      prev_cid  = bus.dev_src_cid_o;
    end
  end

  initial begin
    int pending;
    logic [7:0] tgt;
    int vc;

    rstn             = 1'b0;
    node_x           = 2'd1;
    node_y           = 2'd0;
    bus.flit_v_i     = 1'b0;
    bus.flit_i       = '0;
    bus.flit_vc_id_i = '0;
    bus.dev_ready_i  = 1'b0;
    foreach (exp_cr[i]) begin
      exp_cr[i] = 0;
      got_cr[i] = 0;
      outstanding[i] = 0;
    end
    exp_drop = 0;
    exp_tgt_err = 1'b0;
    exp_ovf_err = 1'b0;

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_dev_v", 256'(bus.dev_v_o), 256'(0));
    check("rst_lcrd_v", 256'(bus.lcrd_v_o), 256'(0));
    check("rst_lcrd_id", 256'(bus.lcrd_id_o), 256'(0));
    check("rst_tgt_err", 256'(bus.tgt_err_o), 256'(0));
    check("rst_ovf_err", 256'(bus.ovf_err_o), 256'(0));
    check("rst_drop_cnt", 256'(bus.drop_cnt_o), 256'(0));
    tick();

    // Single flit latency and credit timing
    bus.dev_ready_i = 1'b1;
    send(0, 8'h01, 2, 1);
    @(negedge clk);
    check("lat_dev_v", 256'(bus.dev_v_o), 256'(1));
    check("lat_cid", 256'(bus.dev_src_cid_o), 256'(5));
    @(negedge clk);
    check("lat_lcrd_v", 256'(bus.lcrd_v_o), 256'(1));
    check("lat_lcrd_id", 256'(bus.lcrd_id_o), 256'(0));
    idle(3);

    // Corner cid decodes
    send(1, 8'h01, 0, 0);
    @(negedge clk);
    check("cid_origin", 256'(bus.dev_src_cid_o), 256'(0));
    idle(2);
    send(1, 8'h01, 3, 0);
    @(negedge clk);
    check("cid_x3", 256'(bus.dev_src_cid_o), 256'(2));
    idle(3);

    // Wrong target: silent drop with a credit
    send(0, 8'h02, 1, 1);
    @(negedge clk);
    check("drop_no_valid", 256'(bus.dev_v_o), 256'(0));
    idle(3);
    @(negedge clk);
    check("drop_tgt_err", 256'(bus.tgt_err_o), 256'(exp_tgt_err));
    check("drop_cnt_tgt", 256'(bus.drop_cnt_o), 256'(sat_drop()));
    tick();

    // Overflow on a stalled VC1
    bus.dev_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) send(1, 8'h01, i % 4, 1);
    idle(2);
    @(negedge clk);
    check("ovf_err", 256'(bus.ovf_err_o), 256'(exp_ovf_err));
    check("ovf_drop_cnt", 256'(bus.drop_cnt_o), 256'(sat_drop()));
    check("ovf_head_valid", 256'(bus.dev_v_o), 256'(1));
    tick();
    bus.dev_ready_i = 1'b1;
    idle(10);
    check("ovf_drained", 256'(exp_q[1].size()), 256'(0));
    check("ovf_credits", 256'(got_cr[1]), 256'(exp_cr[1]));

    // Round-robin between two loaded VCs
    bus.dev_ready_i = 1'b0;
    deliv_log.delete();
    send(0, 8'h01, 1, 2);
    send(1, 8'h01, 2, 2);
    send(0, 8'h01, 3, 2);
    send(1, 8'h01, 0, 3);
    idle(2);
    bus.dev_ready_i = 1'b1;
    idle(10);
    check("rr_count", 256'(deliv_log.size()), 256'(4));
    for (int i = 0; i < 4; i++)
      if (i < deliv_log.size()) check("rr_order", 256'(deliv_log[i]), 256'(i % 2));

    // Reset with buffered flits
    bus.dev_ready_i = 1'b0;
    send(0, 8'h01, 1, 1);
    send(1, 8'h01, 2, 1);
    send(0, 8'h01, 3, 1);
    idle(2);
    for (int v = 0; v < VC_NUM; v++) check("pre_reset_cr", 256'(got_cr[v]), 256'(exp_cr[v] - 2 + v));
    rstn = 1'b0;
    @(negedge clk);
    check("mid_rst_dev_v", 256'(bus.dev_v_o), 256'(0));
    check("mid_rst_lcrd_v", 256'(bus.lcrd_v_o), 256'(0));
    check("mid_rst_lcrd_id", 256'(bus.lcrd_id_o), 256'(0));
    check("mid_rst_tgt_err", 256'(bus.tgt_err_o), 256'(0));
    check("mid_rst_ovf_err", 256'(bus.ovf_err_o), 256'(0));
    check("mid_rst_drop_cnt", 256'(bus.drop_cnt_o), 256'(0));
    for (int v = 0; v < VC_NUM; v++) begin
      exp_q[v].delete();
      exp_cr[v] = 0;
      got_cr[v] = 0;
      outstanding[v] = 0;
    end
    exp_drop = 0;
    exp_tgt_err = 1'b0;
    exp_ovf_err = 1'b0;
    tick();
    rstn = 1'b1;
    bus.dev_ready_i = 1'b1;
    idle(10);
    check("post_rst_credits", 256'(got_cr[0] + got_cr[1]), 256'(0));
    check("post_rst_dev_v", 256'(bus.dev_v_o), 256'(0));

    // Randomized traffic from a credit-respecting router
    for (int n = 0; n < 800; n++) begin
      bus.flit_v_i = 1'b0;
      bus.dev_ready_i = ($urandom_range(0, 3) != 0);
      vc = int'($urandom_range(0, 1));
      if (outstanding[vc] < VC_DEPTH && $urandom_range(0, 2) != 0) begin
        tgt = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h01;
        drive_flit(vc, tgt, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
      tick();
    end
    bus.flit_v_i = 1'b0;
    bus.dev_ready_i = 1'b1;
    pending = 1;
    for (int n = 0; n < 300 && pending != 0; n++) begin
      tick();
      pending = 0;
      for (int v = 0; v < VC_NUM; v++)
        pending += exp_q[v].size() + (exp_cr[v] - got_cr[v]);
    end
    check("drain_pending", 256'(pending), 256'(0));
    @(negedge clk);
    check("rand_drop_cnt", 256'(bus.drop_cnt_o), 256'(sat_drop()));
    check("rand_tgt_err", 256'(bus.tgt_err_o), 256'(exp_tgt_err));
    check("rand_ovf_err", 256'(bus.ovf_err_o), 256'(exp_ovf_err));
    for (int v = 0; v < VC_NUM; v++) check("rand_credits", 256'(got_cr[v]), 256'(exp_cr[v]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
